// File: rtl/pwm_multi_ramp.sv
// Multi-channel PWM generator with prescaled period counter, period-boundary
// shadowed duty registers and an optional per-period slew limit on duty changes.
module pwm_multi_ramp #(
  parameter int CHANNELS  = 2,
  parameter int WIDTH     = 8,
  parameter int PRESCALE  = 1,
  parameter int RAMP_STEP = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [CHANNELS*WIDTH-1:0] duty_req,
  output logic [CHANNELS-1:0]       pwm_out,
  output logic                      period_start,
  output logic [CHANNELS-1:0]       ramp_busy
);

  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] DUTY_FULL = '1;
  // A step of a full period or more always lands on the target, so clamp it
  // to keep the ramp arithmetic inside WIDTH+1 bits.
  localparam int STEP_SAT = (RAMP_STEP >= (1 << WIDTH)) ? (1 << WIDTH) : RAMP_STEP;
  localparam logic [WIDTH:0] STEP = (WIDTH + 1)'(STEP_SAT);

  logic [PRE_W-1:0]  pre;
  logic [WIDTH-1:0]  cnt;
  logic [WIDTH-1:0]  act      [CHANNELS];
  logic [WIDTH-1:0]  act_next [CHANNELS];
  logic [WIDTH-1:0]  tgt      [CHANNELS];
  logic [CHANNELS-1:0] high;
  logic              tick;
  logic              boundary;

  assign tick     = (pre == PRE_LAST);
  assign boundary = tick && (cnt == DUTY_FULL);

  always_comb begin
    high      = '0;
    ramp_busy = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      tgt[i]      = duty_req[i*WIDTH +: WIDTH];
      act_next[i] = act[i];
      if (RAMP_STEP == 0) begin
        act_next[i] = tgt[i];
      end else if (act[i] < tgt[i]) begin
        if (({1'b0, tgt[i]} - {1'b0, act[i]}) <= STEP) act_next[i] = tgt[i];
        else act_next[i] = act[i] + STEP[WIDTH-1:0];
      end else if (act[i] > tgt[i]) begin
        if (({1'b0, act[i]} - {1'b0, tgt[i]}) <= STEP) act_next[i] = tgt[i];
        else act_next[i] = act[i] - STEP[WIDTH-1:0];
      end
      // All-ones is treated as a true 100% duty rather than 2^WIDTH-1 ticks.
      high[i]      = (act[i] == DUTY_FULL) || (cnt < act[i]);
      ramp_busy[i] = (act[i] != tgt[i]);
    end
  end

  // Reset and disable both abort the period and restart every channel from 0.
  always_ff @(posedge clk) begin
    if (!rst || !en) begin
      pre          <= '0;
      cnt          <= '0;
      pwm_out      <= '0;
      period_start <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) act[i] <= '0;
    end else begin
      pre          <= tick ? '0 : pre + 1'b1;
      if (tick) cnt <= cnt + 1'b1;
      if (boundary) begin
        for (int i = 0; i < CHANNELS; i++) act[i] <= act_next[i];
      end
      pwm_out      <= high;
      period_start <= boundary;
    end
  end

endmodule

// File: tb/tb_pwm_multi_ramp.sv
// Bench for pwm_multi_ramp: two configurations (direct load, and prescaled
// with ramp) against a period-arithmetic reference model.
module tb_pwm_multi_ramp;
  localparam int CH     = 2;
  localparam int W      = 4;
  localparam int MAXD   = (1 << W) - 1;
  localparam int PRE_A  = 1;
  localparam int STEP_A = 0;
  localparam int PRE_B  = 3;
  localparam int STEP_B = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en_a = 1'b0;
  logic en_b = 1'b0;
  logic [CH*W-1:0] duty_a = '0;
  logic [CH*W-1:0] duty_b = '0;
  logic [CH-1:0] pwm_a, pwm_b, busy_a, busy_b;
  logic ps_a, ps_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pwm_multi_ramp #(.CHANNELS(CH), .WIDTH(W), .PRESCALE(PRE_A), .RAMP_STEP(STEP_A)) dut_a (
    .clk(clk), .rst(rst), .en(en_a), .duty_req(duty_a),
    .pwm_out(pwm_a), .period_start(ps_a), .ramp_busy(busy_a)
  );

  pwm_multi_ramp #(.CHANNELS(CH), .WIDTH(W), .PRESCALE(PRE_B), .RAMP_STEP(STEP_B)) dut_b (
    .clk(clk), .rst(rst), .en(en_b), .duty_req(duty_b),
    .pwm_out(pwm_b), .period_start(ps_b), .ramp_busy(busy_b)
  );

  // Reference model: enabled-cycle count since restart, active duty per channel.
  int n_m [2];
  int act_m [2][CH];
  logic [CH-1:0] exp_pwm [2];
  logic exp_ps [2];

  function automatic int duty_of(input logic [CH*W-1:0] v, input int i);
    return int'(v[i*W +: W]);
  endfunction

  function automatic int ramp(input int a, input int d, input int s);
    if (s == 0) return d;
    if (a < d) return (a + s < d) ? a + s : d;
    if (a > d) return (a - s > d) ? a - s : d;
    return a;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input int k, input int pre, input int step_sz,
                            input logic en_k, input logic [CH*W-1:0] duty);
    int period_clk;
    int cnt;
    period_clk = pre * (MAXD + 1);
    if (!rst || !en_k) begin
      n_m[k] = 0;
      for (int i = 0; i < CH; i++) act_m[k][i] = 0;
      exp_pwm[k] = '0;
      exp_ps[k] = 1'b0;
    end else begin
      cnt = (n_m[k] / pre) % (MAXD + 1);
      for (int i = 0; i < CH; i++)
        exp_pwm[k][i] = (act_m[k][i] == MAXD) || (cnt < act_m[k][i]);
      n_m[k] = (n_m[k] + 1) % period_clk;
      exp_ps[k] = (n_m[k] == 0);
      if (n_m[k] == 0)
        for (int i = 0; i < CH; i++) act_m[k][i] = ramp(act_m[k][i], duty_of(duty, i), step_sz);
    end
  endtask

  // One clock: advance the model at the edge, compare all outputs at negedge.
  task automatic step();
    logic [CH-1:0] eb_a, eb_b;
    @(posedge clk);
    model_edge(0, PRE_A, STEP_A, en_a, duty_a);
    model_edge(1, PRE_B, STEP_B, en_b, duty_b);
    @(negedge clk);
    for (int i = 0; i < CH; i++) begin
      eb_a[i] = (act_m[0][i] != duty_of(duty_a, i));
      eb_b[i] = (act_m[1][i] != duty_of(duty_b, i));
    end
    chk("pwm_a", pwm_a, exp_pwm[0]);
    chk("ps_a", ps_a, exp_ps[0]);
    chk("busy_a", busy_a, eb_a);
    chk("pwm_b", pwm_b, exp_pwm[1]);
    chk("ps_b", ps_b, exp_ps[1]);
    chk("busy_b", busy_b, eb_b);
  endtask

  task automatic set_duty(input int k, input int d0, input int d1);
    if (k == 0) duty_a = {W'(d1), W'(d0)};
    else duty_b = {W'(d1), W'(d0)};
  endtask

  task automatic wait_ps(input int k, input int limit, output int waited);
    logic seen;
    seen = 1'b0;
    waited = 0;
    for (int c = 0; c < limit && !seen; c++) begin
      step();
      waited++;
      seen = (k == 0) ? ps_a : ps_b;
    end
    chk("period_start_wait", seen, 1'b1);
  endtask

  task automatic count_high(input int k, input int len, output int h0, output int h1, output int psn);
    h0 = 0; h1 = 0; psn = 0;
    for (int c = 0; c < len; c++) begin
      step();
      if (k == 0) begin h0 += int'(pwm_a[0]); h1 += int'(pwm_a[1]); psn += int'(ps_a); end
      else begin h0 += int'(pwm_b[0]); h1 += int'(pwm_b[1]); psn += int'(ps_b); end
    end
  endtask

  typedef struct {
    int d0;
    int d1;
    int h0;
    int h1;
  } vec_t;

  initial begin
    vec_t tbl [6];
    int h0, h1, psn, w, ha, hb;
    int ramp_up [4];
    int ramp_dn [4];
    int rst_at;

    tbl[0] = '{d0: 4,  d1: 15, h0: 4,  h1: 16};
    tbl[1] = '{d0: 10, d1: 0,  h0: 10, h1: 0};
    tbl[2] = '{d0: 1,  d1: 14, h0: 1,  h1: 14};
    tbl[3] = '{d0: 15, d1: 15, h0: 16, h1: 16};
    tbl[4] = '{d0: 0,  d1: 8,  h0: 0,  h1: 8};
    tbl[5] = '{d0: 7,  d1: 3,  h0: 7,  h1: 3};
    ramp_up = '{6, 12, 18, 21};
    ramp_dn = '{21, 15, 9, 6};

    // Reset state, with a nonzero request visible on ramp_busy.
    set_duty(0, 3, 0);
    repeat (3) step();
    chk("reset_pwm_a", pwm_a, 2'b00);
    chk("reset_busy_a", busy_a, 2'b01);
    rst = 1'b1;
    en_a = 1'b1;

    // Direct-load configuration: one full period per table row.
    for (int r = 0; r < 6; r++) begin
      set_duty(0, tbl[r].d0, tbl[r].d1);
      wait_ps(0, 40, w);
      count_high(0, 16, h0, h1, psn);
      chk("tbl_high0", h0, tbl[r].h0);
      chk("tbl_high1", h1, tbl[r].h1);
      chk("tbl_ps_per_period", psn, 1);
    end

    // Mid-period request change only takes effect at the next boundary.
    set_duty(0, 4, 0);
    wait_ps(0, 40, w);
    count_high(0, 16, h0, h1, psn);
    count_high(0, 7, ha, h1, psn);
    set_duty(0, 10, 0);
    count_high(0, 9, hb, h1, psn);
    chk("midchange_keep_old", ha + hb, 4);
    count_high(0, 16, h0, h1, psn);
    chk("midchange_new", h0, 10);
    set_duty(0, 0, 0);
    count_high(0, 16, h0, h1, psn);
    count_high(0, 16, h0, h1, psn);
    chk("duty_zero", h0, 0);

    // Prescaled ramp configuration: 0 -> 7 then 7 -> 2.
    set_duty(1, 7, 0);
    en_b = 1'b1;
    wait_ps(1, 60, w);
    for (int p = 0; p < 4; p++) begin
      chk("ramp_up_busy", busy_b[0], (p < 3) ? 1'b1 : 1'b0);
      count_high(1, 48, h0, h1, psn);
      chk("ramp_up_high", h0, ramp_up[p]);
      chk("ps_spacing_b", psn, 1);
    end
    set_duty(1, 2, 0);
    for (int p = 0; p < 4; p++) begin
      count_high(1, 48, h0, h1, psn);
      chk("ramp_down_high", h0, ramp_dn[p]);
    end
    chk("ramp_down_settled", busy_b[0], 1'b0);

    // Disable mid-period at act=6, then soft-start again.
    set_duty(1, 6, 0);
    count_high(1, 48, h0, h1, psn);
    count_high(1, 48, h0, h1, psn);
    chk("pre_drop_high", h0, 12);
    repeat (4) step();
    chk("pre_drop_pwm", pwm_b[0], 1'b1);
    en_b = 1'b0;
    step();
    chk("en_drop_pwm", pwm_b, 2'b00);
    chk("en_drop_busy", busy_b[0], 1'b1);
    en_b = 1'b1;
    wait_ps(1, 60, w);
    for (int p = 0; p < 3; p++) begin
      count_high(1, 48, h0, h1, psn);
      chk("restart_ramp", h0, 6 * (p + 1));
    end

    // Reset mid-period; counting restarts from zero.
    set_duty(0, 9, 15);
    repeat (21) step();
    rst = 1'b0;
    step();
    chk("midrst_pwm_a", pwm_a, 2'b00);
    chk("midrst_pwm_b", pwm_b, 2'b00);
    chk("midrst_ps", {ps_a, ps_b}, 2'b00);
    rst = 1'b1;
    wait_ps(0, 40, rst_at);
    chk("restart_latency", rst_at, 16);

    // Randomized traffic checked cycle by cycle against the model.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 39) == 0) set_duty(0, $urandom_range(0, MAXD), $urandom_range(0, MAXD));
      if ($urandom_range(0, 39) == 0) set_duty(1, $urandom_range(0, MAXD), $urandom_range(0, MAXD));
      if ($urandom_range(0, 299) == 0) en_b = ~en_b;
      if ($urandom_range(0, 499) == 0) en_a = ~en_a;
      rst = ($urandom_range(0, 699) != 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pwm_multi_ramp.md
# pwm_multi_ramp

Multi-channel PWM generator for the motor-drive path, and the successor to the single-channel 2-bit-speed PWM. It has a parametrised counter width, a clock prescaler and per-channel duty inputs. Duty updates are shadowed so they only take effect at period boundaries, and an optional slew limit (soft-start ramp) moves each channel's duty toward its target. It sits between the speed/control logic and the motor driver pins, one output per motor.

## Interface
- CHANNELS, 2, number of independent PWM outputs (≥1)
- WIDTH, 8, period counter and duty width; period = 2^WIDTH ticks (≥2)
- PRESCALE, 1, clk cycles per counter tick (≥1; 1 = tick every cycle)
- RAMP_STEP, 0, maximum change of active duty per period; 0 = no ramp (target loaded directly)
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  reset, synchronous, active-low
- en  input  1  run enable; low = stopped and outputs forced low
- duty_req  input  CHANNELS*WIDTH  target duty per channel, channel i in bits [i*WIDTH +: WIDTH]
- pwm_out  output  CHANNELS  PWM output per channel, registered
- period_start  output  1  one-cycle pulse at each period boundary
- ramp_busy  output  CHANNELS  high while the channel's active duty ≠ its duty_req

## Operation
- Prescaler `pre` counts 0..PRESCALE-1 while en=1. `tick` is asserted in the cycle where pre = PRESCALE-1; pre wraps to 0 on that edge.
- Period counter `cnt` (WIDTH bits) increments on each tick and wraps from 2^WIDTH-1 to 0.
- A boundary is a tick with cnt = 2^WIDTH-1.
- Active duty `act[i]` (WIDTH bits) is a shadow register. It changes only on a boundary edge, so no mid-period glitches occur.
- Update rule on a boundary, with d = duty_req[i]:
  - RAMP_STEP = 0: act ← d.
  - act < d: act ← min(act+RAMP_STEP, d).
  - act > d: act ← max(act−RAMP_STEP, d).
  - The arithmetic is saturating and never overshoots or wraps. Compute it at WIDTH+1 bits.
- Compare: high = (act[i] = 2^WIDTH-1) OR (cnt < act[i]).
  - All-ones duty is true 100% (constant high).
  - 0 is constant low.
  - Otherwise the output is high for act ticks of the 2^WIDTH period.
- pwm_out[i] registers the compare result each cycle.
- ramp_busy[i] = (act[i] ≠ duty_req[i]). This is combinational from the registered act and the input.
- en = 0 on a clock edge clears pre, cnt and all act to 0 and forces pwm_out to 0.
  - On re-enable, every channel soft-starts from duty 0.
  - This clearing is independent of rst.
- duty_req may change at any time. Only the value present on the boundary edge is used.

## Timing
- Reset (rst=0 at an edge): pre=0, cnt=0, act=0, pwm_out=0, period_start=0. ramp_busy then reflects duty_req≠0.
- rst has priority over en. Reset mid-period aborts the period immediately, with no completion.
- The first edge with rst=1, en=1 starts counting. With PRESCALE=1, cnt=1 after that edge.
- Boundary edge: cnt→0 and act updates on the same edge. The compare in the first cycle of the new period therefore uses the new act.
- Output latency: pwm_out reflects (cnt, act) from the previous cycle, a fixed 1 clk delay. It is the same for all channels, with no inter-channel skew.
- period_start is registered: high for exactly one clk in the cycle after the boundary edge (cnt=0, pre=0).
- Period length = PRESCALE × 2^WIDTH clk. Each high level lasts act × PRESCALE clk.
- en falling: pwm_out is low from the cycle after the edge where en=0 is sampled.
- Ramp from 0 to target T takes ceil(T/RAMP_STEP) boundaries.

## Test plan
- CHANNELS=2, WIDTH=4, PRESCALE=1, RAMP_STEP=0; duty_req ch0=4, ch1=15 -> per 16-cycle period ch0 high 4 cycles, ch1 constant high; period_start pulses every 16 cycles.
- Same config; change ch0 duty_req 4→10 mid-period (cnt=7) -> current period keeps 4 high cycles; next period has 10; duty 0 -> ch0 never high.
- RAMP_STEP=2, ch0 duty_req 0→7 -> act after successive boundaries is 2, 4, 6, 7, then holds; ramp_busy[0] high until the boundary that loads 7. Target then 7→2 -> act 5, 3, 2 with no undershoot.
- PRESCALE=3, WIDTH=4, duty 5 -> period 48 clk, high 15 clk; period_start spacing 48.
- en dropped mid-period with act=6 -> pwm_out low next cycle, cnt/act=0; en raised with RAMP_STEP=2 -> ramp restarts 2, 4, 6.
- rst=0 asserted mid-period with en=1 -> next cycle all outputs 0, cnt=0; counting resumes from 0 after rst=1.
